// File: rtl/wb_arbiter_if.sv
// Bus bundle for wb_arbiter: per-master upstream Wishbone fields (packed by
// master index) and the single downstream port. Signal directions are named
// from the arbiter's point of view; the slave modport is the arbiter side, the
// master modport is the side that drives requests into it.
interface wb_arbiter_if #(
  parameter int unsigned num_masters = 2,
  parameter int unsigned aw          = 32,
  parameter int unsigned dw          = 32
);
  // Upstream (master-facing) signals
  logic [num_masters*aw-1:0]     wbm_adr_i;
  logic [num_masters*dw-1:0]     wbm_dat_i;
  logic [num_masters*(dw/8)-1:0] wbm_sel_i;
  logic [num_masters-1:0]        wbm_we_i;
  logic [num_masters-1:0]        wbm_cyc_i;
  logic [num_masters-1:0]        wbm_stb_i;
  logic [num_masters*3-1:0]      wbm_cti_i;
  logic [num_masters*2-1:0]      wbm_bte_i;
  logic [dw-1:0]                 wbm_sdt_o;
  logic [num_masters-1:0]        wbm_ack_o;
  logic [num_masters-1:0]        wbm_err_o;
  logic [num_masters-1:0]        wbm_rty_o;

  // Downstream (slave-facing) signals
  logic [aw-1:0]                 wbs_adr_o;
  logic [dw-1:0]                 wbs_dat_o;
  logic [dw/8-1:0]               wbs_sel_o;
  logic                          wbs_we_o;
  logic                          wbs_cyc_o;
  logic                          wbs_stb_o;
  logic [2:0]                    wbs_cti_o;
  logic [1:0]                    wbs_bte_o;
  logic [dw-1:0]                 wbs_sdt_i;
  logic                          wbs_ack_i;
  logic                          wbs_err_i;
  logic                          wbs_rty_i;

  // Arbiter side
  modport slave (
    input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
    input  wbm_cti_i, wbm_bte_i,
    output wbm_sdt_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
    output wbs_cti_o, wbs_bte_o,
    input  wbs_sdt_i, wbs_ack_i, wbs_err_i, wbs_rty_i
  );

  // Environment side: drives master requests and slave responses
  modport master (
    output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
    output wbm_cti_i, wbm_bte_i,
    input  wbm_sdt_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
    input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o,
    input  wbs_cti_o, wbs_bte_o,
    output wbs_sdt_i, wbs_ack_i, wbs_err_i, wbs_rty_i
  );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin Wishbone arbiter, num_masters upstream to one
// downstream port. A granted cycle (including bursts) is never pre-empted;
// re-arbitration happens only when the granted master drops cyc.
// Optional feature: define WB_ARBITER_TIMEOUT_EN to add a 16-bit stall
// counter that errors out a slave that never responds within timeout_cycles.
module wb_arbiter #(
  parameter int unsigned num_masters    = 2,
  parameter int unsigned aw             = 32,
  parameter int unsigned dw             = 32,
  parameter int unsigned timeout_cycles = 255
) (
  input  logic                   wb_clk,
  input  logic                   wb_rst_n,
  wb_arbiter_if.slave            io_bus,
  output logic [num_masters-1:0] grant_o
);

  localparam int unsigned IdxW = (num_masters > 1) ? $clog2(num_masters) : 1;
  localparam int unsigned SelW = dw / 8;

  typedef logic [IdxW-1:0] idx_t;
  typedef enum logic {StIdle, StBusy} state_e;

  state_e r_state, w_state_d;
  idx_t   r_gnt, w_gnt_d;
  idx_t   r_last, w_last_d;

  logic   w_busy;
  logic   w_any_cyc;
  logic   w_gnt_cyc;
  logic   w_gnt_stb;
  idx_t   w_sel;
  logic   w_timeout;

  // First requester at or above (from + 1), wrapping modulo num_masters
  function automatic idx_t pick_next(input logic [num_masters-1:0] cyc, input idx_t from);
    idx_t res;
    logic found;
    int   start;
    int   idx;
    res   = '0;
    found = 1'b0;
    start = (int'(from) + 1) % int'(num_masters);
    for (int k = 0; k < int'(num_masters); k++) begin
      idx = (start + k) % int'(num_masters);
      if (!found && cyc[idx]) begin
        res   = idx_t'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign w_busy    = (r_state == StBusy);
  assign w_any_cyc = |io_bus.wbm_cyc_i;
  assign w_gnt_cyc = io_bus.wbm_cyc_i[r_gnt];
  assign w_gnt_stb = io_bus.wbm_stb_i[r_gnt];
  // Idle steers slice 0 onto the downstream request fields
  assign w_sel     = w_busy ? r_gnt : '0;

  // State, grant index and last-winner registers
  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      r_state <= StIdle;
      r_gnt   <= '0;
      r_last  <= idx_t'(num_masters - 1);
    end else begin
      r_state <= w_state_d;
      r_gnt   <= w_gnt_d;
      r_last  <= w_last_d;
    end
  end

  // Next-state: arbitrate from idle, hold while granted cyc stays high
  always_comb begin
    w_state_d = r_state;
    w_gnt_d   = r_gnt;
    w_last_d  = r_last;
    unique case (r_state)
      StIdle: begin
        if (w_any_cyc) begin
          w_state_d = StBusy;
          w_gnt_d   = pick_next(io_bus.wbm_cyc_i, r_last);
        end
      end
      StBusy: begin
        if (!w_gnt_cyc) begin
          w_last_d = r_gnt;
          // Granted cyc is low here, so any high bit belongs to another master
          if (w_any_cyc) begin
            w_state_d = StBusy;
            w_gnt_d   = pick_next(io_bus.wbm_cyc_i, r_gnt);
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

`ifdef WB_ARBITER_TIMEOUT_EN
  logic [15:0] r_stall, w_stall_d;
  logic        w_resp;
  logic        w_stalled;
  logic        w_keep;

  assign w_resp    = io_bus.wbs_ack_i | io_bus.wbs_err_i | io_bus.wbs_rty_i;
  assign w_stalled = w_busy & w_gnt_cyc & w_gnt_stb & ~w_resp;
  // Counter hits the limit in the timeout_cycles-th consecutive stalled cycle
  assign w_timeout = w_stalled && (r_stall == 16'(timeout_cycles - 1));
  // Grant is unchanged across the edge only when staying busy on the same index
  assign w_keep    = w_busy && (w_state_d == StBusy) && (w_gnt_d == r_gnt);

  // Stall counter next value: clear on response, timeout or grant change
  always_comb begin
    w_stall_d = r_stall;
    if (w_resp || w_timeout || !w_keep) begin
      w_stall_d = '0;
    end else if (w_stalled) begin
      w_stall_d = r_stall + 16'd1;
    end
  end

  // Stall counter register
  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      r_stall <= '0;
    end else begin
      r_stall <= w_stall_d;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Outputs: combinational routing of the granted slice and its responses
  always_comb begin
    grant_o          = '0;
    io_bus.wbm_ack_o = '0;
    io_bus.wbm_err_o = '0;
    io_bus.wbm_rty_o = '0;
    io_bus.wbs_cyc_o = 1'b0;
    io_bus.wbs_stb_o = 1'b0;
    io_bus.wbs_adr_o = io_bus.wbm_adr_i[int'(w_sel)*aw +: aw];
    io_bus.wbs_dat_o = io_bus.wbm_dat_i[int'(w_sel)*dw +: dw];
    io_bus.wbs_sel_o = io_bus.wbm_sel_i[int'(w_sel)*SelW +: SelW];
    io_bus.wbs_we_o  = io_bus.wbm_we_i[w_sel];
    io_bus.wbs_cti_o = io_bus.wbm_cti_i[int'(w_sel)*3 +: 3];
    io_bus.wbs_bte_o = io_bus.wbm_bte_i[int'(w_sel)*2 +: 2];
    if (w_busy) begin
      grant_o[r_gnt]          = 1'b1;
      // Timeout drops the slave cycle in the same cycle it reports err
      io_bus.wbs_cyc_o        = w_gnt_cyc & ~w_timeout;
      io_bus.wbs_stb_o        = w_gnt_stb & ~w_timeout;
      io_bus.wbm_ack_o[r_gnt] = io_bus.wbs_ack_i;
      io_bus.wbm_err_o[r_gnt] = io_bus.wbs_err_i | w_timeout;
      io_bus.wbm_rty_o[r_gnt] = io_bus.wbs_rty_i;
    end
  end

  assign io_bus.wbm_sdt_o = io_bus.wbs_sdt_i;

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter num_masters, default 2: number of upstream Wishbone masters, legal range 1..16.
REQ-002 Parameter aw, default 32: address width.
REQ-003 Parameter dw, default 32: data width; select width is dw/8.
REQ-004 Parameter timeout_cycles, default 255: stall limit, legal range 1..65535; used only with the Configuration feature.
REQ-005 wb_clk  in  1  single clock; all state changes on its rising edge.
REQ-006 wb_rst_n  in  1  reset, synchronous, active-low.
REQ-007 wbm_adr_i/wbm_dat_i/wbm_sel_i  in  num_masters*aw / num_masters*dw / num_masters*dw/8  per-master request fields; master i occupies slice i.
REQ-008 wbm_we_i/wbm_cyc_i/wbm_stb_i  in  num_masters each  per-master control.
REQ-009 wbm_cti_i/wbm_bte_i  in  num_masters*3 / num_masters*2  per-master burst fields.
REQ-010 wbm_sdt_o  out  dw  read data, broadcast to all masters.
REQ-011 wbm_ack_o/wbm_err_o/wbm_rty_o  out  num_masters each  per-master response.
REQ-012 wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_cti_o, wbs_bte_o  out  aw, dw, dw/8, 1, 1, 1, 3, 2  single downstream port; feeds the slave-select mux.
REQ-013 wbs_sdt_i/wbs_ack_i/wbs_err_i/wbs_rty_i  in  dw/1/1/1  downstream response.
REQ-014 grant_o  out  num_masters  one-hot current grant; all zero when IDLE.

Function
REQ-015 The block shall implement two states: IDLE and BUSY, plus a grant index register gnt and a last-winner register last.
REQ-016 IDLE with any wbm_cyc_i bit high shall go to BUSY on the next edge, with gnt equal to the first requesting index found searching upward from last+1, modulo num_masters.
REQ-017 BUSY with wbm_cyc_i[gnt] high shall hold gnt unchanged, regardless of other requests; a granted cycle and any burst in it are never pre-empted.
REQ-018 BUSY with wbm_cyc_i[gnt] low shall update last<=gnt on the edge. It shall then re-arbitrate from gnt+1 to BUSY if any other cyc bit is high, else go to IDLE.
REQ-019 Arbitration latency shall be exactly one cycle: a request seen in IDLE at edge n drives wbs_cyc_o high after edge n.
REQ-020 wbs_cyc_o and wbs_stb_o shall equal BUSY AND wbm_cyc_i[gnt] / wbm_stb_i[gnt], combinationally gated, so a dropped cyc ends the slave cycle in the same cycle.
REQ-021 All other wbs_* request outputs shall carry slice gnt combinationally; in IDLE they shall carry slice 0.
REQ-022 wbm_ack_o[gnt], wbm_err_o[gnt] and wbm_rty_o[gnt] shall mirror wbs_ack_i, wbs_err_i and wbs_rty_i while BUSY; all other bits and all bits in IDLE shall be 0.
REQ-023 wbm_sdt_o shall equal wbs_sdt_i at all times.
REQ-024 When num_masters=1, the arbiter shall reduce to a pass-through that still has the one-cycle grant latency.

Reset
REQ-025 wb_rst_n low at an edge shall set the state to IDLE, gnt=0 and last=num_masters-1, so master 0 has first priority.
REQ-026 While the state is IDLE after reset: wbs_cyc_o=0, wbs_stb_o=0, grant_o=0, and all wbm_ack_o/err_o/rty_o=0.
REQ-027 Reset asserted during BUSY shall abort the transaction; any slave response in that cycle shall not be forwarded after the edge.

Configuration
REQ-028 Macro WB_ARBITER_TIMEOUT_EN, when defined, shall add a 16-bit stall counter.
REQ-029 The counter shall increment each cycle with wbs_cyc_o&wbs_stb_o high and no ack, err or rty. It shall clear on any response, on a grant change, and on reset.
REQ-030 When the counter reaches timeout_cycles, the block shall assert wbm_err_o[gnt] for one cycle, force wbs_cyc_o low in that cycle, and clear the counter.
REQ-031 Without WB_ARBITER_TIMEOUT_EN, the block shall contain no counter, and err shall come only from wbs_err_i.

Verification
REQ-032 Single master: with num_masters=2, m0 asserts cyc/stb with adr 0x10 -> after 1 cycle wbs_cyc_o=1, wbs_adr_o=0x10, grant_o=01; the slave ack is routed only to wbm_ack_o[0].
REQ-033 Round-robin: m0 and m1 request continuously from reset -> grant order m0, m1, m0, m1; each handover adds exactly 1 cycle with no gap when the other request is pending.
REQ-034 No pre-emption: m0 runs a 4-beat incrementing burst (cti=010, then 111) while m1 requests -> grant stays 01 for all 4 acks, then becomes 10 on the edge after m0 drops cyc.
REQ-035 Reset mid-cycle: wb_rst_n low while BUSY on m1 -> after the edge, IDLE, grant_o=0, wbs_cyc_o=0; a following request from both masters grants m0 first.
REQ-036 Timeout (macro defined, timeout_cycles=8): the slave never acks -> wbm_err_o[gnt]=1 in the 8th stalled cycle, wbs_cyc_o=0 in the same cycle.
REQ-037 Without the macro, the same stimulus shall hang with no err.
